// File: rtl/lsu_bus_arb_pkg.sv
// Shared types for the two-host LSU bus arbiter and its response-id FIFO.
package lsu_bus_arb_pkg;

    localparam int NumHosts  = 2;
    localparam int AddrWidth = 32;
    localparam int BeWidth   = 4;

    typedef logic [$clog2(NumHosts)-1:0] host_id_t;

    // Request fields whose width does not depend on DataWidth; wdata travels beside it.
    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 we;
        logic [BeWidth-1:0]   be;
    } req_fields_t;

endpackage

// File: rtl/lsu_bus_arb_id_fifo.sv
// In-order FIFO of granted host ids; the head names the owner of the next device response.
module lsu_bus_arb_id_fifo
    import lsu_bus_arb_pkg::*;
#(
    parameter int  Depth = 2,
    localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push,
    input  host_id_t        push_id,
    input  logic            pop,
    output host_id_t        head,
    output logic            full,
    output logic            empty,
    output logic [CntW-1:0] count
);

    host_id_t        mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;

    // Pointers wrap at Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_id;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CntW'(Depth));
    assign empty = (count == '0);

endmodule

// File: rtl/lsu_bus_arbiter.sv
// Two-host to one-device LSU bus arbiter: round-robin with a lock across a stalled
// request, bounded outstanding transactions, and in-order response routing.
module lsu_bus_arbiter
    import lsu_bus_arb_pkg::*;
#(
    parameter int MaxOutstanding = 2,
    parameter int DataWidth      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 h0_req_i,
    input  logic [AddrWidth-1:0] h0_addr_i,
    input  logic                 h0_we_i,
    input  logic [BeWidth-1:0]   h0_be_i,
    input  logic [DataWidth-1:0] h0_wdata_i,
    output logic                 h0_gnt_o,
    output logic                 h0_rvalid_o,
    output logic                 h0_err_o,
    output logic [DataWidth-1:0] h0_rdata_o,

    input  logic                 h1_req_i,
    input  logic [AddrWidth-1:0] h1_addr_i,
    input  logic                 h1_we_i,
    input  logic [BeWidth-1:0]   h1_be_i,
    input  logic [DataWidth-1:0] h1_wdata_i,
    output logic                 h1_gnt_o,
    output logic                 h1_rvalid_o,
    output logic                 h1_err_o,
    output logic [DataWidth-1:0] h1_rdata_o,

    output logic                 dev_req_o,
    output logic [AddrWidth-1:0] dev_addr_o,
    output logic                 dev_we_o,
    output logic [BeWidth-1:0]   dev_be_o,
    output logic [DataWidth-1:0] dev_wdata_o,
    input  logic                 dev_gnt_i,
    input  logic                 dev_rvalid_i,
    input  logic                 dev_err_i,
    input  logic [DataWidth-1:0] dev_rdata_i,

    output logic                 spurious_rvalid_o
);

    localparam int CntW = $clog2(MaxOutstanding + 1);

    logic        [NumHosts-1:0]                req;
    req_fields_t [NumHosts-1:0]                fld;
    logic        [NumHosts-1:0][DataWidth-1:0] wdata;
    logic        [NumHosts-1:0]                gnt;
    logic        [NumHosts-1:0]                rvalid;
    logic        [NumHosts-1:0]                err;

    host_id_t        sel;
    host_id_t        last_q;
    host_id_t        lock_id_q;
    logic            lock_q;
    logic            grant;
    logic            full;
    logic            pop;
    host_id_t        fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;

    assign req      = {h1_req_i, h0_req_i};
    assign fld[0]   = '{addr: h0_addr_i, we: h0_we_i, be: h0_be_i};
    assign fld[1]   = '{addr: h1_addr_i, we: h1_we_i, be: h1_be_i};
    assign wdata[0] = h0_wdata_i;
    assign wdata[1] = h1_wdata_i;

    // A stalled request pins the selection; otherwise a lone requester wins and ties alternate.
    always_comb begin
        sel = ~last_q;
        if (lock_q)              sel = lock_id_q;
        else if (req[0] ^ req[1]) sel = host_id_t'(req[1]);
    end

    // full comes from the registered count, so a same-cycle response cannot reopen the bus.
    assign full        = (fifo_count == CntW'(MaxOutstanding));
    assign dev_req_o   = req[sel] & ~full & ~rst_i;
    assign dev_addr_o  = fld[sel].addr;
    assign dev_we_o    = fld[sel].we;
    assign dev_be_o    = fld[sel].be;
    assign dev_wdata_o = wdata[sel];
    assign grant       = dev_req_o & dev_gnt_i;

    assign pop               = dev_rvalid_i & ~fifo_empty & ~rst_i;
    assign spurious_rvalid_o = dev_rvalid_i & fifo_empty & ~rst_i;

    for (genvar n = 0; n < NumHosts; n++) begin : g_host
        assign gnt[n]    = grant & (sel == host_id_t'(n));
        assign rvalid[n] = pop & (fifo_head == host_id_t'(n));
        assign err[n]    = rvalid[n] & dev_err_i;
    end

    assign h0_gnt_o    = gnt[0];
    assign h1_gnt_o    = gnt[1];
    assign h0_rvalid_o = rvalid[0];
    assign h1_rvalid_o = rvalid[1];
    assign h0_err_o    = err[0];
    assign h1_err_o    = err[1];
    assign h0_rdata_o  = dev_rdata_i;
    assign h1_rdata_o  = dev_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            last_q    <= host_id_t'(1);
        end else if (grant) begin
            lock_q <= 1'b0;
            last_q <= sel;
        end else if (dev_req_o) begin
            lock_q    <= 1'b1;
            lock_id_q <= sel;
        end
    end

    lsu_bus_arb_id_fifo #(
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (grant & ~fifo_full),
        .push_id (sel),
        .pop     (pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// Scoreboard bench for lsu_bus_arbiter: expected grants and responses are queued as
// stimulus is driven and retired by a negedge monitor as the DUT produces them.
module tb_lsu_bus_arbiter;

    typedef struct {
        logic        host;
        logic [31:0] addr;
    } gnt_exp_t;

    typedef struct {
        logic        host;
        logic [31:0] data;
        logic        err;
    } rsp_exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        h0_req_i, h1_req_i;
    logic [31:0] h0_addr_i, h1_addr_i;
    logic        h0_we_i, h1_we_i;
    logic [3:0]  h0_be_i, h1_be_i;
    logic [31:0] h0_wdata_i, h1_wdata_i;
    logic        h0_gnt_o, h1_gnt_o, h0_rvalid_o, h1_rvalid_o, h0_err_o, h1_err_o;
    logic [31:0] h0_rdata_o, h1_rdata_o;
    logic        dev_req_o, dev_we_o, dev_gnt_i, dev_rvalid_i, dev_err_i;
    logic [31:0] dev_addr_o, dev_wdata_o, dev_rdata_i;
    logic [3:0]  dev_be_o;
    logic        spurious_rvalid_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_spur   = 0;
    int exp_spur = 0;
    gnt_exp_t exp_gnt_q[$];
    rsp_exp_t exp_rsp_q[$];

    always #5 clk_i = ~clk_i;

    lsu_bus_arbiter #(.MaxOutstanding(2), .DataWidth(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .h0_req_i(h0_req_i), .h0_addr_i(h0_addr_i), .h0_we_i(h0_we_i), .h0_be_i(h0_be_i),
        .h0_wdata_i(h0_wdata_i), .h0_gnt_o(h0_gnt_o), .h0_rvalid_o(h0_rvalid_o),
        .h0_err_o(h0_err_o), .h0_rdata_o(h0_rdata_o),
        .h1_req_i(h1_req_i), .h1_addr_i(h1_addr_i), .h1_we_i(h1_we_i), .h1_be_i(h1_be_i),
        .h1_wdata_i(h1_wdata_i), .h1_gnt_o(h1_gnt_o), .h1_rvalid_o(h1_rvalid_o),
        .h1_err_o(h1_err_o), .h1_rdata_o(h1_rdata_o),
        .dev_req_o(dev_req_o), .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o),
        .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o), .dev_gnt_i(dev_gnt_i),
        .dev_rvalid_i(dev_rvalid_i), .dev_err_i(dev_err_i), .dev_rdata_i(dev_rdata_i),
        .spurious_rvalid_o(spurious_rvalid_o)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic exp_g(input logic host, input logic [31:0] addr);
        gnt_exp_t e;
        e.host = host;
        e.addr = addr;
        exp_gnt_q.push_back(e);
    endtask

    task automatic exp_r(input logic host, input logic [31:0] data, input logic err);
        rsp_exp_t e;
        e.host = host;
        e.data = data;
        e.err  = err;
        exp_rsp_q.push_back(e);
    endtask

    // Monitor: retire grants and responses against the scoreboard.
    always @(negedge clk_i) begin
        gnt_exp_t g;
        rsp_exp_t r;
        if (!rst_i) begin
            if (h0_gnt_o || h1_gnt_o) begin
                if (exp_gnt_q.size() == 0) chk("gnt_unexpected", {h1_gnt_o, h0_gnt_o}, 0);
                else begin
                    g = exp_gnt_q.pop_front();
                    chk("gnt_host", {h1_gnt_o, h0_gnt_o}, g.host ? 2'b10 : 2'b01);
                    chk("gnt_addr", dev_addr_o, g.addr);
                end
            end
            if (h0_rvalid_o || h1_rvalid_o) begin
                if (exp_rsp_q.size() == 0) chk("rsp_unexpected", {h1_rvalid_o, h0_rvalid_o}, 0);
                else begin
                    r = exp_rsp_q.pop_front();
                    chk("rsp_host", {h1_rvalid_o, h0_rvalid_o}, r.host ? 2'b10 : 2'b01);
                    chk("rsp_data", r.host ? h1_rdata_o : h0_rdata_o, r.data);
                    chk("rsp_err", {h1_err_o, h0_err_o}, r.err ? (r.host ? 2'b10 : 2'b01) : 2'b00);
                end
            end
            chk("err_idle", {h1_err_o & ~h1_rvalid_o, h0_err_o & ~h0_rvalid_o}, 0);
            if (spurious_rvalid_o) n_spur++;
        end
    end

    initial begin
        rst_i = 1'b1;
        h0_req_i = 1'b1; h1_req_i = 1'b0;
        h0_addr_i = 32'h0; h1_addr_i = 32'h0;
        h0_we_i = 1'b0; h1_we_i = 1'b1;
        h0_be_i = 4'hF; h1_be_i = 4'h3;
        h0_wdata_i = 32'h1111_0000; h1_wdata_i = 32'h2222_0000;
        dev_gnt_i = 1'b1; dev_rvalid_i = 1'b1; dev_err_i = 1'b1; dev_rdata_i = 32'h0;

        // Reset: outputs held quiet even with request, grant and rvalid active.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_dev_req", dev_req_o, 0);
        chk("rst_gnt", {h1_gnt_o, h0_gnt_o}, 0);
        chk("rst_rsp", {h1_rvalid_o, h0_rvalid_o, h1_err_o, h0_err_o, spurious_rvalid_o}, 0);
        cyc();
        rst_i = 1'b0; h0_req_i = 1'b0; dev_gnt_i = 1'b0; dev_rvalid_i = 1'b0; dev_err_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_req", dev_req_o, 0);
        chk("post_rst_spur", spurious_rvalid_o, 0);

        // Tie right after reset: h0 first, then h1.
        cyc();
        h0_req_i = 1'b1; h0_addr_i = 32'h100; h1_req_i = 1'b1; h1_addr_i = 32'h200; dev_gnt_i = 1'b1;
        exp_g(0, 32'h100); exp_g(1, 32'h200);
        @(negedge clk_i);
        chk("tie_c0_h0_gnt", h0_gnt_o, 1);
        chk("tie_c0_we", dev_we_o, 0);
        chk("tie_c0_wdata", dev_wdata_o, 32'h1111_0000);
        cyc();
        h0_req_i = 1'b0;
        @(negedge clk_i);
        chk("tie_c1_h1_gnt", h1_gnt_o, 1);
        chk("tie_c1_be", dev_be_o, 4'h3);
        cyc();
        h1_req_i = 1'b0; dev_gnt_i = 1'b0;
        dev_rvalid_i = 1'b1; dev_rdata_i = 32'h11; exp_r(0, 32'h11, 0);
        cyc();
        dev_rdata_i = 32'h22; exp_r(1, 32'h22, 0);
        cyc();
        dev_rvalid_i = 1'b0;

        // Stalled h1 request keeps the bus locked even though h0 would win a tie.
        cyc();
        h1_req_i = 1'b1; h1_addr_i = 32'h300;
        @(negedge clk_i);
        chk("lock_c0_addr", dev_addr_o, 32'h300);
        cyc();
        h0_req_i = 1'b1; h0_addr_i = 32'h400;
        @(negedge clk_i);
        chk("lock_c1_addr", dev_addr_o, 32'h300);
        chk("lock_c1_h0_gnt", h0_gnt_o, 0);
        cyc();
        @(negedge clk_i);
        chk("lock_c2_addr", dev_addr_o, 32'h300);
        cyc();
        dev_gnt_i = 1'b1; exp_g(1, 32'h300);
        @(negedge clk_i);
        chk("lock_c3_h1_gnt", h1_gnt_o, 1);
        cyc();
        h1_req_i = 1'b0; exp_g(0, 32'h400);
        @(negedge clk_i);
        chk("lock_c4_h0_gnt", h0_gnt_o, 1);
        cyc();
        h0_req_i = 1'b0; dev_gnt_i = 1'b0;
        dev_rvalid_i = 1'b1; dev_rdata_i = 32'h33; exp_r(1, 32'h33, 0);
        cyc();
        dev_rdata_i = 32'h44; exp_r(0, 32'h44, 0);
        cyc();
        dev_rvalid_i = 1'b0;

        // Outstanding limit: third request waits for a response, then issues a cycle later.
        cyc();
        h0_req_i = 1'b1; h0_addr_i = 32'h500; dev_gnt_i = 1'b1; exp_g(0, 32'h500);
        cyc();
        h0_addr_i = 32'h504; exp_g(0, 32'h504);
        cyc();
        h0_addr_i = 32'h508;
        @(negedge clk_i);
        chk("full_c2_req", dev_req_o, 0);
        cyc();
        @(negedge clk_i);
        chk("full_c3_req", dev_req_o, 0);
        cyc();
        dev_rvalid_i = 1'b1; dev_rdata_i = 32'h55; exp_r(0, 32'h55, 0);
        @(negedge clk_i);
        chk("full_pop_req", dev_req_o, 0);
        cyc();
        dev_rvalid_i = 1'b0; exp_g(0, 32'h508);
        @(negedge clk_i);
        chk("full_after_req", dev_req_o, 1);
        cyc();
        h0_req_i = 1'b0; dev_gnt_i = 1'b0;
        dev_rvalid_i = 1'b1; dev_rdata_i = 32'h56; exp_r(0, 32'h56, 0);
        cyc();
        dev_rdata_i = 32'h57; exp_r(0, 32'h57, 0);
        cyc();
        dev_rvalid_i = 1'b0;

        // Grants h0, h1, h0 with in-order responses A, B (error), C; push and pop overlap.
        cyc();
        h0_req_i = 1'b1; h0_addr_i = 32'h600; dev_gnt_i = 1'b1; exp_g(0, 32'h600);
        cyc();
        h0_req_i = 1'b0; h1_req_i = 1'b1; h1_addr_i = 32'h700; exp_g(1, 32'h700);
        cyc();
        h1_req_i = 1'b0; h0_req_i = 1'b1; h0_addr_i = 32'h800;
        dev_rvalid_i = 1'b1; dev_rdata_i = 32'hA; exp_r(0, 32'hA, 0);
        cyc();
        exp_g(0, 32'h800);
        dev_rdata_i = 32'hB; dev_err_i = 1'b1; exp_r(1, 32'hB, 1);
        @(negedge clk_i);
        chk("ord_h1_err", h1_err_o, 1);
        cyc();
        h0_req_i = 1'b0; dev_gnt_i = 1'b0;
        dev_rdata_i = 32'hC; dev_err_i = 1'b0; exp_r(0, 32'hC, 0);
        cyc();
        dev_rvalid_i = 1'b0;

        // Spurious response on an empty FIFO, then reset discarding an outstanding id.
        cyc();
        dev_rvalid_i = 1'b1; dev_err_i = 1'b1; dev_rdata_i = 32'hDEAD; exp_spur++;
        @(negedge clk_i);
        chk("spur1_pulse", spurious_rvalid_o, 1);
        chk("spur1_rsp", {h1_rvalid_o, h0_rvalid_o, h1_err_o, h0_err_o}, 0);
        cyc();
        dev_rvalid_i = 1'b0; dev_err_i = 1'b0;
        h1_req_i = 1'b1; h1_addr_i = 32'h900; dev_gnt_i = 1'b1; exp_g(1, 32'h900);
        @(negedge clk_i);
        chk("spur_pre_gnt", h1_gnt_o, 1);
        cyc();
        h1_req_i = 1'b0; dev_gnt_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i);
        chk("mid_rst_out", {dev_req_o, h1_gnt_o, h0_gnt_o, spurious_rvalid_o}, 0);
        cyc();
        rst_i = 1'b0; dev_rvalid_i = 1'b1; dev_rdata_i = 32'hBEEF; exp_spur++;
        @(negedge clk_i);
        chk("spur2_pulse", spurious_rvalid_o, 1);
        chk("spur2_rsp", {h1_rvalid_o, h0_rvalid_o}, 0);
        cyc();
        dev_rvalid_i = 1'b0;
        cyc();
        @(negedge clk_i);
        chk("gnt_q_drained", exp_gnt_q.size(), 0);
        chk("rsp_q_drained", exp_rsp_q.size(), 0);
        chk("spur_count", n_spur, exp_spur);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_bus_arbiter.md
LSU_BUS_ARBITER -- requirements
Module: lsu_bus_arbiter

Interface
REQ-001 Parameter MaxOutstanding, default 2, SHALL set the maximum number of granted transactions awaiting a response (1..4).
REQ-002 Parameter DataWidth, default 32, SHALL set the width of the wdata and rdata buses.
REQ-003 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 h{0,1}_req_i  in  1  host N request; held with stable fields until granted.
REQ-006 h{0,1}_addr_i / _we_i / _be_i / _wdata_i  in  32/1/4/DataWidth  host N request fields.
REQ-007 h{0,1}_gnt_o  out  1  host N request accepted this cycle.
REQ-008 h{0,1}_rvalid_o / _err_o  out  1/1  host N response valid and bus error.
REQ-009 h{0,1}_rdata_o  out  DataWidth  response data, a copy of dev_rdata_i.
REQ-010 dev_req_o / dev_addr_o / dev_we_o / dev_be_o / dev_wdata_o  out  1/32/1/4/DataWidth  device-side request.
REQ-011 dev_gnt_i / dev_rvalid_i / dev_err_i / dev_rdata_i  in  1/1/1/DataWidth  device-side grant and response.
REQ-012 spurious_rvalid_o  out  1  single-cycle pulse for a dev_rvalid_i that arrives with no outstanding transaction.

Function
REQ-013 Selection SHALL be made as follows, in priority order:
- when lock_q is set, the selected host SHALL be lock_id_q;
- otherwise, when exactly one host requests, that host SHALL be selected;
- otherwise, when both hosts request, the selected host SHALL be ~last_q (round-robin).
REQ-014 dev_req_o SHALL equal the selected host's req AND NOT full, where full means count == MaxOutstanding.
REQ-015 dev_addr_o, dev_we_o, dev_be_o and dev_wdata_o SHALL be driven combinationally from the selected host.
REQ-016 hN_gnt_o SHALL equal dev_gnt_i AND dev_req_o AND (selected == N); the grant SHALL pass through with zero latency.
REQ-017 When dev_req_o is asserted and dev_gnt_i is not, the block SHALL set lock_q and lock_id_q to the selected host, so selection cannot change mid-request.
REQ-018 On a grant, the block SHALL clear lock_q, set last_q to the selected host, and push the selected host's id into the id FIFO.
REQ-019 When dev_rvalid_i is asserted and the FIFO is non-empty, the block SHALL assert hN_rvalid_o for N equal to the FIFO head, pass dev_err_i to hN_err_o, and pop the head in the same cycle.
REQ-020 When dev_rvalid_i is asserted and the FIFO is empty, the block SHALL assert no host rvalid, pulse spurious_rvalid_o, and leave all state unchanged.
REQ-021 A push and a pop in the same cycle SHALL leave count unchanged; FIFO read and write pointers SHALL wrap modulo MaxOutstanding.
REQ-022 When full, dev_req_o SHALL remain low even if a pop occurs in the same cycle; there SHALL be no combinational path from rvalid to req.
REQ-023 The rvalid outputs of the non-addressed host and all err outputs outside a response cycle SHALL be 0.
REQ-024 A host that deasserts req while locked is a protocol violation; the block SHALL hold the lock until that host is granted.

Reset
REQ-025 While rst_i is asserted, the block SHALL set count=0, both FIFO pointers=0, lock_q=0, lock_id_q=0 and last_q=1, so that h0 wins the first tie.
REQ-026 Reset asserted mid-transaction SHALL discard outstanding ids; a dev_rvalid_i after reset SHALL be treated as spurious.
REQ-027 During and immediately after reset, all gnt, rvalid, err and spurious outputs SHALL be 0 and dev_req_o SHALL be 0.

Structure
REQ-028 A shared package lsu_bus_arb_pkg SHALL hold NumHosts=2, the host_id_t typedef and the request field struct.
REQ-029 The id FIFO SHALL be a sub-module, lsu_bus_arb_id_fifo, with push, pop, head, full, empty and count ports and a synchronous active-high reset.

Verification
REQ-030 Both hosts request, address 0x100 (h0) and 0x200 (h1), dev_gnt_i=1, on the first cycle after reset -> h0 is granted in cycle 0 and h1 in cycle 1; dev_addr_o is 0x100 then 0x200.
REQ-031 h1 requests, dev_gnt_i=0 for 3 cycles, and h0 raises req in cycle 1 -> dev_addr_o stays h1's address; h1 is granted in cycle 3 and h0 in cycle 4.
REQ-032 With MaxOutstanding=2, three back-to-back grants are attempted with no rvalid -> the third request sees dev_req_o=0 until the first dev_rvalid_i, then the request issues one cycle later.
REQ-033 Grants to h0, h1, h0, then three rvalids with rdata 0xA, 0xB, 0xC and err on the second -> h0 gets 0xA, h1 gets 0xB with h1_err_o=1, h0 gets 0xC.
REQ-034 dev_rvalid_i while the FIFO is empty, then rst_i pulsed with one transaction outstanding -> spurious_rvalid_o pulses both times and no host rvalid is asserted.
